// File: rtl/pipelined_rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder/subtractor.
package pipelined_rca_pkg;

    localparam int MAX_STAGES = 8;

    function automatic int chunk_lo(input int k, input int cw);
        return k * cw;
    endfunction

    function automatic logic ovf(input logic cin_msb, input logic cout_msb);
        return cin_msb ^ cout_msb;
    endfunction

endpackage

// File: rtl/pipelined_rca_chunk.sv
// One pipeline stage's worth of combinational ripple: CW full-adder cells in series.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout,
    output logic          c_msb_in
);
    logic [CW:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CW; i++) begin : g_cell
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout     = c[CW];
    assign c_msb_in = c[CW-1];
endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: S stages of W/S bits, valid/ready on both ends,
// per-stage valid bits so bubbles collapse and back-pressure fills the pipe.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int W = 16,
    parameter int S = 4
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         overflow
);
    localparam int CW = W / S;

    if (W < 2 || S < 1 || S > W || S > MAX_STAGES || (W % S) != 0) begin : g_param_check
        $error("pipelined_rca: unsupported W=%0d S=%0d", W, S);
    end

    logic [W-1:0] b_eff;
    logic         cin_eff;

    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : c_in;

    logic [S-1:0] valid_q;
    logic [S-1:0] v_in;
    logic [S:0]   load;
    logic [W-1:0] a_s   [S];
    logic [W-1:0] b_s   [S];
    logic [W-1:0] sum_s [S];
    logic [S-1:0] carry_s;
    logic         ovf_q;

    // Ready ripples back from the output: a stage may load if empty or if its successor loads.
    always_comb begin
        load    = '0;
        load[S] = out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            load[k] = ~valid_q[k] | load[k+1];
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[S-1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q <= '0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (load[k]) valid_q[k] <= v_in[k];
            end
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int LO = chunk_lo(k, CW);

        logic [W-1:0]  a_in, b_in, sum_in, sum_d;
        logic [W-1:0]  a_q, b_q, sum_q;
        logic          cin_k, carry_q;
        logic [CW-1:0] cs;
        logic          ccout, cmsb;

        if (k == 0) begin : g_src
            assign a_in    = a;
            assign b_in    = b_eff;
            assign cin_k   = cin_eff;
            assign sum_in  = '0;
            assign v_in[k] = in_valid;
        end else begin : g_src
            assign a_in    = a_s[k-1];
            assign b_in    = b_s[k-1];
            assign cin_k   = carry_s[k-1];
            assign sum_in  = sum_s[k-1];
            assign v_in[k] = valid_q[k-1];
        end

        rca_chunk #(.CW(CW)) u_chunk (
            .a        (a_in[LO +: CW]),
            .b        (b_in[LO +: CW]),
            .cin      (cin_k),
            .s        (cs),
            .cout     (ccout),
            .c_msb_in (cmsb)
        );

        always_comb begin
            sum_d          = sum_in;
            sum_d[LO +: CW] = cs;
        end

        // Data only moves with a valid source so the output holds its last result over bubbles.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                a_q     <= '0;
                b_q     <= '0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (load[k] && v_in[k]) begin
                a_q     <= a_in;
                b_q     <= b_in;
                sum_q   <= sum_d;
                carry_q <= ccout;
            end
        end

        assign a_s[k]     = a_q;
        assign b_s[k]     = b_q;
        assign sum_s[k]   = sum_q;
        assign carry_s[k] = carry_q;

        if (k == S - 1) begin : g_last
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    ovf_q <= 1'b0;
                end else if (load[k] && v_in[k]) begin
                    ovf_q <= ovf(cmsb, ccout);
                end
            end
        end
    end

    assign sum      = sum_s[S-1];
    assign c_out    = carry_s[S-1];
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed and random checks of the 16-bit, 4-stage pipelined adder/subtractor.
module tb_pipelined_rca;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        c_in, sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out, overflow;

    int errors = 0;
    int checks = 0;

    pipelined_rca #(.W(16), .S(4)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] be;
        logic        cie;
        logic [16:0] full;
        logic [15:0] low;
        be   = sb ? ~y : y;
        cie  = sb ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, be} + {16'b0, cie};
        low  = {1'b0, x[14:0]} + {1'b0, be[14:0]} + {15'b0, cie};
        return {low[15] ^ full[16], full[16], full[15:0]};
    endfunction

    // Call at a falling edge with the pipe idle or draining; checks latency and result.
    task automatic apply_one(input vec_t v, input string tag);
        int lat;
        a = v.a; b = v.b; c_in = v.cin; sub = v.sub; in_valid = 1'b1;
        #1;
        chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge aclk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge aclk);
            lat++;
        end
        chk({tag, " latency"}, lat, 32'd4);
        chk({tag, " sum"}, {16'b0, sum}, {16'b0, v.sum});
        chk({tag, " c_out"}, {31'b0, c_out}, {31'b0, v.cout});
        chk({tag, " overflow"}, {31'b0, overflow}, {31'b0, v.ovf});
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[8]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0};

        aresetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

        repeat (2) @(negedge aclk);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset sum", {16'b0, sum}, 32'd0);
        chk("reset c_out", {31'b0, c_out}, 32'd0);
        chk("reset overflow", {31'b0, overflow}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post-reset in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) apply_one(vecs[i], $sformatf("vec%0d", i));
        @(negedge aclk);

        // Back-pressure: fill the pipe with out_ready low.
        begin
            int acc;
            int idx;
            int r;
            int first;
            int last;
            acc = 0;
            out_ready = 1'b0;
            for (int c = 0; c < 8; c++) begin
                a = acc[15:0]; b = acc[15:0] + 16'd1; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
                #1;
                if (in_ready) acc++;
                @(negedge aclk);
            end
            chk("bp accepts", acc, 32'd4);
            chk("bp in_ready low", {31'b0, in_ready}, 32'd0);
            chk("bp out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp head sum", {16'b0, sum}, 32'd1);
            repeat (2) @(negedge aclk);
            chk("bp hold sum", {16'b0, sum}, 32'd1);

            out_ready = 1'b1;
            a = 16'd4; b = 16'd5; in_valid = 1'b1;
            #1;
            chk("bp full accept+drain", {31'b0, in_ready}, 32'd1);
            idx = 4; r = 0; first = -1; last = -1;
            for (int c = 0; c < 16; c++) begin
                if (out_valid) begin
                    chk($sformatf("bp result %0d", r), {16'b0, sum}, 2 * r + 1);
                    if (first < 0) first = c;
                    last = c;
                    r++;
                end
                if (in_valid && in_ready) idx++;
                @(negedge aclk);
                in_valid = (idx < 6);
                a = idx[15:0]; b = idx[15:0] + 16'd1;
                #1;
            end
            chk("bp result count", r, 32'd6);
            chk("bp back-to-back", last - first, 32'd5);
        end

        // Random traffic against the reference model.
        @(negedge aclk);
        begin
            logic [17:0] q[$];
            logic [17:0] exp;
            logic [17:0] hold_val;
            logic        hold_pend;
            int sent, rcvd, cyc;
            sent = 0; rcvd = 0; cyc = 0; hold_pend = 1'b0; hold_val = '0;
            while ((sent < 1000 || rcvd < sent) && cyc < 20000) begin
                in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
                a         = $urandom_range(0, 65535);
                b         = $urandom_range(0, 65535);
                c_in      = $urandom_range(0, 1) == 1;
                sub       = $urandom_range(0, 1) == 1;
                out_ready = $urandom_range(0, 1) == 1;
                #1;
                if (hold_pend) begin
                    chk("rnd hold", {13'b0, out_valid, overflow, c_out, sum}, {13'b0, 1'b1, hold_val});
                end
                if (in_valid && in_ready) begin
                    q.push_back(model(a, b, c_in, sub));
                    sent++;
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd spurious: out_valid with sum %h but nothing accepted", sum);
                    end else begin
                        exp = q.pop_front();
                        chk($sformatf("rnd result %0d", rcvd), {14'b0, overflow, c_out, sum}, {14'b0, exp});
                    end
                    rcvd++;
                end
                hold_pend = out_valid && !out_ready;
                hold_val  = {overflow, c_out, sum};
                @(negedge aclk);
                cyc++;
            end
            chk("rnd received", rcvd, 32'd1000);
        end

        // Mid-stream reset discards everything in flight.
        in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; c_in = 1'b0;
        repeat (2) @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
            a = 16'h0100 * (i + 1); b = 16'h0001; in_valid = 1'b1;
            @(negedge aclk);
        end
        in_valid = 1'b0;
        aresetn  = 1'b0;
        #1;
        chk("mid-reset out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge aclk);
        chk("mid-reset held out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid-reset held sum", {16'b0, sum}, 32'd0);
        aresetn = 1'b1;
        begin
            int stale;
            stale = 0;
            repeat (6) begin
                @(negedge aclk);
                if (out_valid) stale++;
            end
            chk("mid-reset stale results", stale, 32'd0);
        end
        begin
            vec_t v;
            v = '{16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0};
            apply_one(v, "post-reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_rca.md
Name: pipelined_rca

Overview:
Parametrised, pipelined ripple-carry adder/subtractor built from full-adder cells and split into S register stages of W/S bits each. It accepts one operand pair per cycle over a valid/ready handshake and returns sum, carry-out and signed overflow S cycles later. Per-stage valid bits let the pipeline absorb back-pressure and collapse bubbles. It is the characterisation vehicle for multi-bit adder timing, replacing single-cell full-adder measurements.

Parameters:
W, 16, operand and sum width in bits; W >= 2
S, 4, number of pipeline stages; 1 <= S <= W and W % S == 0; elaboration error otherwise
CW, W/S, derived chunk width per stage (localparam, not overridable)

Ports:
aclk  input  1  clock, rising edge
aresetn  input  1  asynchronous active-low reset
in_valid  input  1  operand transaction valid
in_ready  output  1  pipeline can accept an operand transaction this cycle
a  input  W  operand A, unsigned/two's complement
b  input  W  operand B
c_in  input  1  carry-in, used when sub=0
sub  input  1  1 = compute a - b
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  W  result bits
c_out  output  1  carry out of MSB (for sub, 1 = no borrow)
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (aresetn=0, asynchronous): all stage valid bits clear. out_valid=0, sum=0, c_out=0, overflow=0. in_ready=1 during reset is don't-care; in_ready is 1 from the first cycle after release.
- Operand conditioning at input: b_eff = sub ? ~b : b; cin_eff = sub ? 1 : c_in (c_in is ignored when sub=1).
- Stage k (0..S-1) register holds:
  - valid_k.
  - Sum bits [(k+1)*CW-1:0] already computed.
  - Unconsumed upper operand bits of a and b_eff.
  - Carry into chunk k+1.
  - Carry into the MSB, kept only when the MSB lies in chunk k.
- Each stage ripples CW full-adder cells combinationally on its chunk.
- Stage S-1 register drives sum, c_out and overflow directly. There is no combinational path from the inputs to the outputs.
- Transfer rules:
  - Input accept: in_valid && in_ready at a rising edge.
  - Output accept: out_valid && out_ready.
  - out_valid = valid_{S-1}.
- Advance rule: stage k loads from stage k-1 (or from the inputs for k=0) when valid_k==0 or stage k+1 loads this edge. Stage S-1 "loads" when out_ready==1 or valid_{S-1}==0.
  - If stage k loads from an invalid source, valid_k goes to 0 (bubble collapse).
- in_ready = (valid_0==0) || stage 1 loads this edge. in_ready depends combinationally on out_ready through the ready chain; this is accepted for S <= 8.
- Latency: with out_ready held at 1, a transaction accepted at edge t shows out_valid=1 after edge t+S-1. Throughput is 1 result per cycle.
- Back-pressure: while out_ready=0, outputs hold stable (sum/c_out/overflow unchanged while out_valid=1). Upstream stages keep filling until every valid bit is set; then in_ready=0. No transaction is dropped or duplicated, and order is preserved.
- Simultaneous accept and drain when full: with all S stages valid and out_ready=1, in_ready=1 and a new operand is accepted in the same cycle.
- Outputs while out_valid=0 hold their last value; this is not checked.
- Reset asserted mid-operation: all in-flight transactions are discarded immediately. There is no partial output.
- S==1 degenerates to a single registered W-bit ripple adder, latency 1 edge.

Decomposition:
- Package pipelined_rca_pkg:
  - function chunk_lo(k, CW) returning the chunk base index.
  - function ovf(cin_msb, cout_msb).
  - Shared localparam for the maximum supported S (8), used in an elaboration assertion.
- Sub-module rca_chunk: CW-bit combinational ripple of full_adder instances.
  - Ports: a, b, cin; outputs s, cout, c_msb_in.
  - Instantiated once per stage via generate.

Test Plan (W=16, S=4):
- Reset release, out_ready=1; accept a=16'hFFFF, b=16'h0001, c_in=0, sub=0 at edge 0 -> after edge 3: out_valid=1, sum=16'h0000, c_out=1, overflow=0.
- a=16'h7FFF, b=16'h0001, c_in=0, sub=0 -> sum=16'h8000, c_out=0, overflow=1. Then a=16'h1234, b=16'h0FFF, c_in=1 -> sum=16'h2234, c_out=0, overflow=0.
- sub=1, a=16'h0005, b=16'h0007, c_in=1 (ignored) -> sum=16'hFFFE, c_out=0, overflow=0. Then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, c_out=1, overflow=1.
- Back-pressure: stream 6 back-to-back operands (i, i+1 for i=0..5) with out_ready=0 -> in_ready falls to 0 after 4 accepts and sum holds 16'h0001. Raise out_ready -> results 1,3,5,7,9,11 emerge in order, one per cycle, with none lost.
- Random throughput: 1000 random operand sets with random in_valid/out_ready (50%) -> every result matches the reference model in order, and out_valid never asserts without a prior accept.
- Mid-stream reset: accept 3 transactions, assert aresetn=0 for 1 cycle before any emerge -> out_valid=0 immediately. After release, no stale results appear; a new transaction completes with correct latency (4 edges).
